// File: rtl/div_result_writeback_pkg.sv
// Shared definitions for the divider result write-back stage:
// FSM state encoding and the default operand width.
package div_result_writeback_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [2:0] {
    st_idle = 3'd0,
    st_fix  = 3'd1,
    st_lo   = 3'd2,
    st_hi   = 3'd3,
    st_done = 3'd4
  } state_t;

endpackage

// File: rtl/div_result_writeback_sign_fix.sv
// Conditional two's-complement negate. Negating 0 gives 0, and negating
// the most negative value wraps back to itself (no overflow indication).
module div_result_writeback_sign_fix
  import div_result_writeback_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] din,
  input  logic             neg,
  output logic [WIDTH-1:0] dout
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Pass through or invert-and-increment depending on neg
  always_comb begin
    dout = din;
    if (neg) begin
      dout = ~din + ONE;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/div_result_writeback.sv
// Divider result write-back: captures the divider's {remainder, quotient}
// word, applies sign correction for signed DIV, loads HI/LO, then writes
// LO and HI onto the shared bus in two granted beats before pulsing done.
module div_result_writeback
  import div_result_writeback_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int BUS_BEATS = 1
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] RZ,
  input  logic               signed_op,
  input  logic               sign_a,
  input  logic               sign_b,
  input  logic               div_zero,
  output logic [WIDTH-1:0]   HI,
  output logic [WIDTH-1:0]   LO,
  output logic               dz_flag,
  output logic               bus_req,
  input  logic               bus_gnt,
  output logic               bus_drive,
  output logic [WIDTH-1:0]   bus_out,
  output logic               done
);

  state_t             state_r;
  state_t             state_next_s;

  logic [2*WIDTH-1:0] z_r;
  logic               signed_r;
  logic               sign_a_r;
  logic               sign_b_r;
  logic               div_zero_r;

  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               dz_flag_r;

  logic               neg_hi_s;
  logic               neg_lo_s;
  logic [WIDTH-1:0]   hi_fix_s;
  logic [WIDTH-1:0]   lo_fix_s;

  logic               in_ready_s;
  logic               bus_req_s;
  logic               bus_drive_s;
  logic [WIDTH-1:0]   bus_out_s;
  logic               done_s;

  // FSM state register; clear abandons any in-flight beat
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_r <= st_idle;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; bus phases stall until granted
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      st_idle: begin
        if (in_valid) state_next_s = st_fix;
        else          state_next_s = st_idle;
      end
      st_fix: begin
        if (BUS_BEATS != 0) state_next_s = st_lo;
        else                state_next_s = st_done;
      end
      st_lo: begin
        if (bus_gnt) state_next_s = st_hi;
        else         state_next_s = st_lo;
      end
      st_hi: begin
        if (bus_gnt) state_next_s = st_done;
        else         state_next_s = st_hi;
      end
      st_done: state_next_s = st_idle;
      default: state_next_s = st_idle;
    endcase
  end

  // FSM output decode from the registered state
  always_comb begin
    in_ready_s  = 1'b0;
    bus_req_s   = 1'b0;
    bus_drive_s = 1'b0;
    bus_out_s   = {WIDTH{1'b0}};
    done_s      = 1'b0;
    case (state_r)
      st_idle: in_ready_s = 1'b1;
      st_fix:  in_ready_s = 1'b0;
      st_lo: begin
        bus_req_s   = 1'b1;
        bus_drive_s = bus_gnt;
        bus_out_s   = lo_r;
      end
      st_hi: begin
        bus_req_s   = 1'b1;
        bus_drive_s = bus_gnt;
        bus_out_s   = hi_r;
      end
      st_done: done_s = 1'b1;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Capture the divider word and sideband only when accepting in IDLE
  always_ff @(posedge clock) begin
    if (!clear) begin
      z_r        <= {(2*WIDTH){1'b0}};
      signed_r   <= 1'b0;
      sign_a_r   <= 1'b0;
      sign_b_r   <= 1'b0;
      div_zero_r <= 1'b0;
    end else if ((state_r == st_idle) && in_valid) begin
      z_r        <= RZ;
      signed_r   <= signed_op;
      sign_a_r   <= sign_a;
      sign_b_r   <= sign_b;
      div_zero_r <= div_zero;
    end else begin
      z_r        <= z_r;
      signed_r   <= signed_r;
      sign_a_r   <= sign_a_r;
      sign_b_r   <= sign_b_r;
      div_zero_r <= div_zero_r;
    end
  end

  // Quotient takes the sign of a^b, remainder the dividend's sign; none on /0
  always_comb begin
    neg_lo_s = signed_r & (sign_a_r ^ sign_b_r) & ~div_zero_r;
    neg_hi_s = signed_r & sign_b_r & ~div_zero_r;
  end

  div_result_writeback_sign_fix #(.WIDTH(WIDTH)) u_sign_fix_lo (
    .din  (z_r[WIDTH-1:0]),
    .neg  (neg_lo_s),
    .dout (lo_fix_s)
  );

  div_result_writeback_sign_fix #(.WIDTH(WIDTH)) u_sign_fix_hi (
    .din  (z_r[2*WIDTH-1:WIDTH]),
    .neg  (neg_hi_s),
    .dout (hi_fix_s)
  );

  // HI/LO/dz_flag load in FIX and hold otherwise, including across IDLE
  always_ff @(posedge clock) begin
    if (!clear) begin
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      dz_flag_r <= 1'b0;
    end else if (state_r == st_fix) begin
      hi_r      <= hi_fix_s;
      lo_r      <= div_zero_r ? {WIDTH{1'b1}} : lo_fix_s;
      dz_flag_r <= div_zero_r;
    end else begin
      hi_r      <= hi_r;
      lo_r      <= lo_r;
      dz_flag_r <= dz_flag_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign bus_req   = bus_req_s;
  assign bus_drive = bus_drive_s;
  assign bus_out   = bus_out_s;
  assign done      = done_s;
  assign HI        = hi_r;
  assign LO        = lo_r;
  assign dz_flag   = dz_flag_r;

endmodule

// File: tb/tb_div_result_writeback.sv
// Self-checking bench for div_result_writeback: expected bus beats are
// queued when an op is driven and popped as the DUT drives the bus.
module tb_div_result_writeback;

  logic        clock = 1'b0;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] RZ;
  logic        signed_op;
  logic        sign_a;
  logic        sign_b;
  logic        div_zero;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        dz_flag;
  logic        bus_req;
  logic        bus_gnt;
  logic        bus_drive;
  logic [31:0] bus_out;
  logic        done;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  div_result_writeback #(.WIDTH(32), .BUS_BEATS(1)) u_dut (
    .clock     (clock),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .RZ        (RZ),
    .signed_op (signed_op),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .div_zero  (div_zero),
    .HI        (HI),
    .LO        (LO),
    .dz_flag   (dz_flag),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .bus_drive (bus_drive),
    .bus_out   (bus_out),
    .done      (done)
  );

  // Reference correction written from the arithmetic rules
  function automatic logic [63:0] model(input logic [63:0] rz, input logic so,
                                        input logic sa, input logic sb, input logic dz);
    logic [31:0] q, r, lo, hi;
    q = rz[31:0];
    r = rz[63:32];
    if (dz) begin
      lo = 32'hFFFF_FFFF;
      hi = r;
    end else if (so) begin
      lo = (sa != sb) ? (32'd0 - q) : q;
      hi = sb ? (32'd0 - r) : r;
    end else begin
      lo = q;
      hi = r;
    end
    return {hi, lo};
  endfunction

  // Drive one op, service the bus with the given stalls, and check everything
  task automatic run_op(input string name, input logic [63:0] rz, input logic so,
                        input logic sa, input logic sb, input logic dz,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dz, input int stall_lo, input int stall_hi);
    int cyc, waited, beats, lat, exp_lat;
    logic busy_err;
    logic [31:0] e;
    exp_lat = 4 + stall_lo + stall_hi;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept: got %b want 1", name, in_ready);
    end
    exp_q.push_back(exp_lo);
    exp_q.push_back(exp_hi);
    in_valid = 1'b1; RZ = rz; signed_op = so; sign_a = sa; sign_b = sb; div_zero = dz;
    bus_gnt = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    RZ = {$urandom(), $urandom()};
    signed_op = 1'($urandom()); sign_a = 1'($urandom());
    sign_b = 1'($urandom()); div_zero = 1'($urandom());
    cyc = 1; waited = 0; beats = 0; lat = 0; busy_err = 1'b0;
    while (lat == 0 && cyc < 64) begin
      if (bus_req) begin
        waited++;
        bus_gnt = (waited > ((beats == 0) ? stall_lo : stall_hi));
      end else begin
        bus_gnt = 1'b0;
      end
      #1;
      if (bus_drive) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_beat: got %h want no beat", name, bus_out);
        end else begin
          e = exp_q.pop_front();
          if (bus_out !== e) begin
            errors++;
            $display("FAIL %s beat%0d: got %h want %h", name, beats, bus_out, e);
          end
        end
        beats++;
        waited = 0;
      end
      if (done) begin
        lat = cyc;
      end else begin
        if (in_ready) busy_err = 1'b1;
        @(posedge clock); #1;
        cyc++;
      end
    end
    bus_gnt = 1'b0;
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d (0 = timeout)", name, lat, exp_lat);
    end
    checks++;
    if (beats != 2) begin
      errors++;
      $display("FAIL %s beat_count: got %0d want 2", name, beats);
    end
    checks++;
    if (busy_err) begin
      errors++;
      $display("FAIL %s in_ready_busy: got 1 want 0", name);
    end
    checks++;
    if (HI !== exp_hi || LO !== exp_lo || dz_flag !== exp_dz) begin
      errors++;
      $display("FAIL %s result: got HI=%h LO=%h dz=%b want HI=%h LO=%h dz=%b",
               name, HI, LO, dz_flag, exp_hi, exp_lo, exp_dz);
    end
    checks++;
    if (bus_out !== 32'd0 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL %s bus_idle_at_done: got out=%h req=%b want 0/0", name, bus_out, bus_req);
    end
    exp_q.delete();
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after_done: got done=%b ready=%b want 0/1", name, done, in_ready);
    end
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (HI !== exp_hi || LO !== exp_lo || dz_flag !== exp_dz) begin
      errors++;
      $display("FAIL %s hold_in_idle: got HI=%h LO=%h dz=%b want HI=%h LO=%h dz=%b",
               name, HI, LO, dz_flag, exp_hi, exp_lo, exp_dz);
    end
  endtask

  task automatic test_reset();
    clear = 1'b0; in_valid = 1'b0; RZ = 64'd0; signed_op = 1'b0;
    sign_a = 1'b0; sign_b = 1'b0; div_zero = 1'b0; bus_gnt = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (in_ready !== 1'b1 || HI !== 32'd0 || LO !== 32'd0 || dz_flag !== 1'b0 ||
        done !== 1'b0 || bus_req !== 1'b0 || bus_drive !== 1'b0 || bus_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b HI=%h LO=%h dz=%b done=%b req=%b drv=%b out=%h want 1/0/0/0/0/0/0/0",
               in_ready, HI, LO, dz_flag, done, bus_req, bus_drive, bus_out);
    end
    clear = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_unsigned();
    run_op("unsigned_100_7", {32'd2, 32'd14}, 1'b0, 1'b0, 1'b0, 1'b0,
           32'd2, 32'd14, 1'b0, 0, 0);
  endtask

  task automatic test_signed();
    run_op("signed_m100_7", {32'd2, 32'd14}, 1'b1, 1'b0, 1'b1, 1'b0,
           32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 0, 0);
    run_op("signed_100_m7", {32'd2, 32'd14}, 1'b1, 1'b1, 1'b0, 1'b0,
           32'd2, 32'hFFFF_FFF2, 1'b0, 0, 0);
    run_op("signed_m100_m7", {32'd2, 32'd14}, 1'b1, 1'b1, 1'b1, 1'b0,
           32'hFFFF_FFFE, 32'd14, 1'b0, 0, 0);
  endtask

  task automatic test_wrap();
    run_op("negate_min_and_zero", {32'd0, 32'h8000_0000}, 1'b1, 1'b0, 1'b1, 1'b0,
           32'd0, 32'h8000_0000, 1'b0, 0, 0);
  endtask

  task automatic test_div_zero();
    run_op("div_zero", {32'd55, 32'hFFFF_FFFF}, 1'b1, 1'b1, 1'b1, 1'b1,
           32'd55, 32'hFFFF_FFFF, 1'b1, 0, 0);
    run_op("dz_cleared", {32'd1, 32'd3}, 1'b0, 1'b0, 1'b0, 1'b0,
           32'd1, 32'd3, 1'b0, 0, 0);
  endtask

  task automatic test_stall();
    run_op("stall_3_2", {32'd9, 32'd77}, 1'b0, 1'b0, 1'b0, 1'b0,
           32'd9, 32'd77, 1'b0, 3, 2);
  endtask

  task automatic test_clear_mid_op();
    logic any_done, any_req;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_mid ready_before: got %b want 1", in_ready);
    end
    in_valid = 1'b1; RZ = {32'd7, 32'd9}; signed_op = 1'b0;
    sign_a = 1'b0; sign_b = 1'b0; div_zero = 1'b1; bus_gnt = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0; div_zero = 1'b0;
    @(posedge clock); #1;
    bus_gnt = 1'b1; #1;
    checks++;
    if (bus_drive !== 1'b1 || bus_out !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL clear_mid lo_beat: got drv=%b out=%h want 1/ffffffff", bus_drive, bus_out);
    end
    @(posedge clock); #1;
    bus_gnt = 1'b0; #1;
    checks++;
    if (bus_req !== 1'b1 || bus_drive !== 1'b0 || bus_out !== 32'd7) begin
      errors++;
      $display("FAIL clear_mid in_hi: got req=%b drv=%b out=%h want 1/0/00000007", bus_req, bus_drive, bus_out);
    end
    clear = 1'b0;
    @(posedge clock); #1;
    clear = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || HI !== 32'd0 || LO !== 32'd0 || dz_flag !== 1'b0 ||
        done !== 1'b0 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL clear_mid after_clear: got ready=%b HI=%h LO=%h dz=%b done=%b req=%b want 1/0/0/0/0/0",
               in_ready, HI, LO, dz_flag, done, bus_req);
    end
    any_done = 1'b0; any_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (done) any_done = 1'b1;
      if (bus_req) any_req = 1'b1;
    end
    checks++;
    if (any_done || any_req) begin
      errors++;
      $display("FAIL clear_mid no_replay: got done=%b req=%b want 0/0", any_done, any_req);
    end
    run_op("fresh_after_clear", {32'd4, 32'd25}, 1'b1, 1'b1, 1'b0, 1'b0,
           32'd4, 32'hFFFF_FFE7, 1'b0, 1, 0);
  endtask

  task automatic test_random();
    logic [63:0] rz, res;
    logic so, sa, sb, dz;
    for (int i = 0; i < 6; i++) begin
      rz = {$urandom(), $urandom()};
      so = 1'($urandom()); sa = 1'($urandom()); sb = 1'($urandom());
      dz = ($urandom_range(0, 4) == 0);
      res = model(rz, so, sa, sb, dz);
      run_op("random", rz, so, sa, sb, dz, res[63:32], res[31:0], dz,
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_wrap();
    test_div_zero();
    test_stall();
    test_clear_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
